// File: rtl/fin_pkg.sv
// fin_collect shared types: FILL/FULL state, lane count, select width.
// Also used by the final address mux and its select driver.
package fin_pkg;

  localparam int FIN_NUM_DIR = 10;
  localparam int FIN_SEL_W   = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fin_state_e;

  function automatic logic lane_hit(
    input logic [FIN_SEL_W-1:0] sel,
    input int                   idx
  );
    return sel == FIN_SEL_W'(idx);
  endfunction

endpackage

// File: rtl/fin_lane_reg.sv
// One signed lane of the collector: write-enabled register,
// cleared asynchronously by active-low reset.
module fin_lane_reg #(
  parameter int W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic signed [W-1:0] i_d,
  output logic signed [W-1:0] o_q
);

  logic signed [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fin_collect.sv
// Deserializing lane collector: fills NUM_DIR lanes, presents a frame.
// Define FIN_COLLECT_OVERLAP_EN to accept a beat on the handshake edge.
module fin_collect
  import fin_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_DIR       = FIN_NUM_DIR
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic signed [ADDRESS_WIDTH-1:0] Din,
  input  logic                            din_valid,
  input  logic                            din_last,
  output logic                            din_ready,
  output logic [FIN_SEL_W-1:0]            select,
  output logic signed [ADDRESS_WIDTH-1:0] Dout0,
  output logic signed [ADDRESS_WIDTH-1:0] Dout1,
  output logic signed [ADDRESS_WIDTH-1:0] Dout2,
  output logic signed [ADDRESS_WIDTH-1:0] Dout3,
  output logic signed [ADDRESS_WIDTH-1:0] Dout4,
  output logic signed [ADDRESS_WIDTH-1:0] Dout5,
  output logic signed [ADDRESS_WIDTH-1:0] Dout6,
  output logic signed [ADDRESS_WIDTH-1:0] Dout7,
  output logic signed [ADDRESS_WIDTH-1:0] Dout8,
  output logic signed [ADDRESS_WIDTH-1:0] Dout9,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            frame_err
);

  localparam int NOUT = 10;
  localparam logic [FIN_SEL_W-1:0] LAST =
    FIN_SEL_W'(NUM_DIR - 1);

  fin_state_e r_state;
  fin_state_e w_state_nxt;

  logic [FIN_SEL_W-1:0] r_sel;
  logic [FIN_SEL_W-1:0] w_sel_nxt;
  logic [FIN_SEL_W-1:0] w_wsel;
  logic                 r_err;

  logic w_accept;
  logic w_at_end;
  logic w_close;
  logic w_mis;

  logic signed [ADDRESS_WIDTH-1:0] w_lane [NOUT];

  // FSM: state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL: begin
        if (w_close) w_state_nxt = FULL;
      end
      FULL: begin
        if (dout_ready) begin
          w_state_nxt = w_close ? FULL : FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    unique case (r_state)
      FILL: din_ready = 1'b1;
      FULL: begin
        dout_valid = 1'b1;
`ifdef FIN_COLLECT_OVERLAP_EN
        din_ready  = dout_ready;
`endif
      end
      default: ;
    endcase
  end

  // a beat taken in FULL starts the next frame at lane 0
  assign w_accept = din_valid & din_ready;
  assign w_wsel   = (r_state == FULL) ? '0 : r_sel;
  assign w_at_end = (w_wsel == LAST);
  assign w_close  = w_accept & (din_last | w_at_end);
  assign w_mis    = w_accept & (din_last ^ w_at_end);

  always_comb begin
    w_sel_nxt = r_sel;
    if (w_accept) begin
      w_sel_nxt = w_close ? w_wsel : w_wsel + 1'b1;
    end else if (r_state == FULL && dout_ready) begin
      w_sel_nxt = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sel <= '0;
      r_err <= 1'b0;
    end else begin
      r_sel <= w_sel_nxt;
      if (w_mis) r_err <= 1'b1;
    end
  end

  assign select    = r_sel;
  assign frame_err = r_err;

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_lane
    if (gi < NUM_DIR) begin : g_reg
      fin_lane_reg #(
        .W (ADDRESS_WIDTH)
      ) u_lane (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_we    (w_accept & lane_hit(w_wsel, gi)),
        .i_d     (Din),
        .o_q     (w_lane[gi])
      );
    end else begin : g_tie
      assign w_lane[gi] = '0;
    end
  end

  // lanes past the visible outputs are still kept
  for (genvar gi = NOUT; gi < NUM_DIR; gi++) begin : g_hid
    logic signed [ADDRESS_WIDTH-1:0] w_q;
    fin_lane_reg #(
      .W (ADDRESS_WIDTH)
    ) u_lane (
      .i_clk   (Clk),
      .i_rst_n (Reset_n),
      .i_we    (w_accept & lane_hit(w_wsel, gi)),
      .i_d     (Din),
      .o_q     (w_q)
    );
  end

  assign Dout0 = w_lane[0];
  assign Dout1 = w_lane[1];
  assign Dout2 = w_lane[2];
  assign Dout3 = w_lane[3];
  assign Dout4 = w_lane[4];
  assign Dout5 = w_lane[5];
  assign Dout6 = w_lane[6];
  assign Dout7 = w_lane[7];
  assign Dout8 = w_lane[8];
  assign Dout9 = w_lane[9];

endmodule

// File: tb/tb_fin_collect.sv
// Self-checking bench for fin_collect against a frame-level model.
// Honours FIN_COLLECT_OVERLAP_EN for the throughput expectation.
module tb_fin_collect;

  localparam int ND = 10;
`ifdef FIN_COLLECT_OVERLAP_EN
  localparam int PERIOD = 10;
  localparam bit OVL = 1'b1;
`else
  localparam int PERIOD = 11;
  localparam bit OVL = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic signed [7:0] Din = '0;
  logic              din_valid = 1'b0;
  logic              din_last = 1'b0;
  logic              dout_ready = 1'b0;
  logic              din_ready;
  logic [3:0]        select;
  logic signed [7:0] Dout0, Dout1, Dout2, Dout3, Dout4;
  logic signed [7:0] Dout5, Dout6, Dout7, Dout8, Dout9;
  logic              dout_valid;
  logic              frame_err;

  logic signed [7:0] obs [ND];
  assign obs[0] = Dout0;
  assign obs[1] = Dout1;
  assign obs[2] = Dout2;
  assign obs[3] = Dout3;
  assign obs[4] = Dout4;
  assign obs[5] = Dout5;
  assign obs[6] = Dout6;
  assign obs[7] = Dout7;
  assign obs[8] = Dout8;
  assign obs[9] = Dout9;

  fin_collect #(
    .ADDRESS_WIDTH (8),
    .NUM_DIR       (ND)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Din        (Din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .select     (select),
    .Dout0      (Dout0),
    .Dout1      (Dout1),
    .Dout2      (Dout2),
    .Dout3      (Dout3),
    .Dout4      (Dout4),
    .Dout5      (Dout5),
    .Dout6      (Dout6),
    .Dout7      (Dout7),
    .Dout8      (Dout8),
    .Dout9      (Dout9),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [7:0] m_lane [ND];
  bit                m_err;

  // frame-level model: overwrite lanes up to the closing beat
  function automatic void model_frame(
    input logic signed [7:0] w[$],
    input int                lastpos
  );
    for (int k = 0; k < w.size(); k++) begin
      m_lane[k] = w[k];
      if (k == lastpos || k == ND - 1) begin
        if ((k == lastpos) != (k == ND - 1)) m_err = 1'b1;
        break;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ND; i++) m_lane[i] = '0;
    m_err = 1'b0;
  endfunction

  task automatic send_beat(
    input logic signed [7:0] w,
    input bit                last,
    input int                gap
  );
    repeat (gap) @(negedge Clk);
    Din = w;
    din_last = last;
    din_valid = 1'b1;
    #1;
    for (int n = 0; !din_ready; n++) begin
      if (n > 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout din_ready=%0b want 1", din_ready);
        break;
      end
      @(negedge Clk);
      #1;
    end
    @(negedge Clk);
    din_valid = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic send_frame(
    input logic signed [7:0] w[$],
    input int                lastpos,
    input int                gap
  );
    for (int k = 0; k < w.size(); k++) begin
      send_beat(w[k], k == lastpos, gap);
    end
    model_frame(w, lastpos);
  endtask

  task automatic release_frame();
    dout_ready = 1'b1;
    @(negedge Clk);
    dout_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_cmp++;
    if (dout_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_dout_valid got %0b want 0", dout_valid);
    end
    n_cmp++;
    if (din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_din_ready got %0b want 1", din_ready);
    end
    n_cmp++;
    if (select !== 4'd0 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_sel_err got %0d/%0b want 0/0",
               select, frame_err);
    end
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (obs[i] !== 8'sd0) begin
        n_bad++;
        $display("FAIL rst_lane%0d got %0d want 0", i, obs[i]);
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic_frame();
    logic signed [7:0] w[$];
    for (int k = 0; k < ND; k++) w.push_back(8'(k));
    for (int k = 0; k < ND - 1; k++) send_beat(w[k], 1'b0, 0);
    #1;
    n_cmp++;
    if (dout_valid !== 1'b0 || select !== 4'd9) begin
      n_bad++;
      $display("FAIL basic_pre got valid=%0b sel=%0d want 0/9",
               dout_valid, select);
    end
    send_beat(w[ND-1], 1'b1, 0);
    model_frame(w, ND - 1);
    #1;
    n_cmp++;
    if (dout_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_valid got %0b want 1", dout_valid);
    end
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (obs[i] !== m_lane[i]) begin
        n_bad++;
        $display("FAIL basic_lane%0d got %0d want %0d",
                 i, obs[i], m_lane[i]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (din_ready !== 1'b0 || dout_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL basic_hold got rdy=%0b vld=%0b want 0/1",
                 din_ready, dout_valid);
      end
      @(negedge Clk);
    end
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_err got %0b want 0", frame_err);
    end
    dout_ready = 1'b1;
    #1;
    n_cmp++;
    if (din_ready !== OVL) begin
      n_bad++;
      $display("FAIL basic_ovl_rdy got %0b want %0b", din_ready, OVL);
    end
    @(negedge Clk);
    dout_ready = 1'b0;
    #1;
    n_cmp++;
    if (dout_valid !== 1'b0 || select !== 4'd0 || din_ready !== 1'b1)
    begin
      n_bad++;
      $display("FAIL basic_rel got vld=%0b sel=%0d rdy=%0b want 0/0/1",
               dout_valid, select, din_ready);
    end
  endtask

  task automatic test_extremes();
    logic signed [7:0] w[$];
    w.push_back(-8'sd128);
    w.push_back(8'sd127);
    for (int k = 2; k < ND; k++) w.push_back(8'($urandom));
    send_frame(w, ND - 1, 0);
    #1;
    n_cmp++;
    if (Dout0 !== -8'sd128 || Dout1 !== 8'sd127) begin
      n_bad++;
      $display("FAIL extreme got %0d/%0d want -128/127", Dout0, Dout1);
    end
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (obs[i] !== m_lane[i]) begin
        n_bad++;
        $display("FAIL extreme_lane%0d got %0d want %0d",
                 i, obs[i], m_lane[i]);
      end
    end
    release_frame();
  endtask

  task automatic test_gapped();
    logic signed [7:0] w[$];
    for (int k = 0; k < ND; k++) w.push_back(8'($urandom));
    send_frame(w, ND - 1, 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (dout_valid !== 1'b1 || din_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL gap_full got vld=%0b rdy=%0b want 1/0",
                 dout_valid, din_ready);
      end
      for (int i = 0; i < ND; i++) begin
        n_cmp++;
        if (obs[i] !== m_lane[i]) begin
          n_bad++;
          $display("FAIL gap_lane%0d c%0d got %0d want %0d",
                   i, c, obs[i], m_lane[i]);
        end
      end
      Din = 8'($urandom);
      @(negedge Clk);
    end
    release_frame();
  endtask

  task automatic test_short_frame();
    logic signed [7:0] w[$];
    logic signed [7:0] v[$];
    for (int k = 0; k < 4; k++) w.push_back(8'($urandom));
    send_frame(w, 3, 0);
    #1;
    n_cmp++;
    if (dout_valid !== 1'b1 || frame_err !== m_err) begin
      n_bad++;
      $display("FAIL short_close got vld=%0b err=%0b want 1/%0b",
               dout_valid, frame_err, m_err);
    end
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (obs[i] !== m_lane[i]) begin
        n_bad++;
        $display("FAIL short_lane%0d got %0d want %0d",
                 i, obs[i], m_lane[i]);
      end
    end
    release_frame();
    for (int k = 0; k < ND; k++) v.push_back(8'($urandom));
    send_frame(v, ND - 1, 0);
    #1;
    n_cmp++;
    if (frame_err !== 1'b1) begin
      n_bad++;
      $display("FAIL short_sticky got %0b want 1", frame_err);
    end
    release_frame();
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      logic signed [7:0] w[$];
      int len;
      int lp;
      len = $urandom_range(1, ND);
      if (len == ND) lp = ($urandom_range(0, 3) != 0) ? ND - 1 : -1;
      else lp = len - 1;
      for (int k = 0; k < len; k++) w.push_back(8'($urandom));
      send_frame(w, lp, $urandom_range(0, 2));
      #1;
      n_cmp++;
      if (dout_valid !== 1'b1 || frame_err !== m_err) begin
        n_bad++;
        $display("FAIL rnd%0d got vld=%0b err=%0b want 1/%0b",
                 f, dout_valid, frame_err, m_err);
      end
      for (int i = 0; i < ND; i++) begin
        n_cmp++;
        if (obs[i] !== m_lane[i]) begin
          n_bad++;
          $display("FAIL rnd%0d_lane%0d got %0d want %0d",
                   f, i, obs[i], m_lane[i]);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      release_frame();
    end
  endtask

  task automatic test_mid_reset();
    logic signed [7:0] w[$];
    for (int k = 0; k < 4; k++) send_beat(8'($urandom), 1'b0, 0);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (select !== 4'd0 || dout_valid !== 1'b0 || frame_err !== 1'b0)
    begin
      n_bad++;
      $display("FAIL mrst got sel=%0d vld=%0b err=%0b want 0/0/0",
               select, dout_valid, frame_err);
    end
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (obs[i] !== 8'sd0) begin
        n_bad++;
        $display("FAIL mrst_lane%0d got %0d want 0", i, obs[i]);
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < ND; k++) w.push_back(8'($urandom));
    send_frame(w, ND - 1, 0);
    #1;
    n_cmp++;
    if (dout_valid !== 1'b1 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL mrst_after got vld=%0b err=%0b want 1/0",
               dout_valid, frame_err);
    end
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (obs[i] !== m_lane[i]) begin
        n_bad++;
        $display("FAIL mrst_after_lane%0d got %0d want %0d",
                 i, obs[i], m_lane[i]);
      end
    end
    release_frame();
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    int rises[$];
    bit prev;
    dout_ready = 1'b1;
    prev = dout_valid;
    for (int cyc = 0; cyc < 70; cyc++) begin
      din_valid = 1'b1;
      din_last = ((cnt % ND) == ND - 1);
      Din = 8'(cnt * 7 + 3);
      #1;
      if (din_ready) begin
        m_lane[cnt % ND] = Din;
        cnt++;
      end
      @(negedge Clk);
      if (dout_valid && !prev) begin
        rises.push_back(cyc);
        for (int i = 0; i < ND; i++) begin
          n_cmp++;
          if (obs[i] !== m_lane[i]) begin
            n_bad++;
            $display("FAIL b2b_lane%0d c%0d got %0d want %0d",
                     i, cyc, obs[i], m_lane[i]);
          end
        end
      end
      prev = dout_valid;
    end
    din_valid = 1'b0;
    din_last = 1'b0;
    dout_ready = 1'b0;
    n_cmp++;
    if (rises.size() < 4) begin
      n_bad++;
      $display("FAIL b2b_count got %0d want >=4", rises.size());
    end
    for (int r = 1; r < rises.size(); r++) begin
      n_cmp++;
      if (rises[r] - rises[r-1] != PERIOD) begin
        n_bad++;
        $display("FAIL b2b_period got %0d want %0d",
                 rises[r] - rises[r-1], PERIOD);
      end
    end
    n_cmp++;
    if (frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_err got %0b want 0", frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_extremes();
    test_gapped();
    test_short_frame();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
